// File: rtl/onehot_decoder_seq.sv
// Registered select-to-LED decoder with one-hot, thermometer, walking-one and bounce modes.
// Optional one-hot checker on led enabled by defining ONEHOT_DECODER_SEQ_CHECK_EN.
module onehot_decoder_seq #(
  parameter int W_IN  = 3,
  parameter int W_OUT = 2**W_IN,
  parameter int DIV   = 4,
  parameter int W_DIV = $clog2(DIV) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [W_IN-1:0]  sel,
  input  logic             load,
  output logic [W_OUT-1:0] led,
  output logic [W_IN-1:0]  idx,
  output logic             dir,
  output logic             wrap,
  output logic             err
);

  typedef enum logic [1:0] {
    M_DECODE = 2'b00,
    M_THERMO = 2'b01,
    M_WALK   = 2'b10,
    M_BOUNCE = 2'b11
  } mode_e;

  // Thermometer is built one bit wider so the top index yields all ones.
  function automatic logic [W_OUT-1:0] pattern(mode_e m, logic [W_IN-1:0] i);
    logic [W_OUT:0] one;
    logic [W_OUT:0] t;
    one = {{W_OUT{1'b0}}, 1'b1};
    if (m == M_THERMO) t = ((one << i) << 1) - one;
    else               t = one << i;
    return t[W_OUT-1:0];
  endfunction

  mode_e            mode_in;
  mode_e            mode_q;
  logic [W_OUT-1:0] led_q, led_d;
  logic [W_IN-1:0]  idx_q, idx_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic [W_DIV-1:0] cnt_q, cnt_d;
  logic             chg, tick, up;

  assign mode_in = mode_e'(mode);
  assign chg     = (mode_in != mode_q);
  assign tick    = en && (cnt_q == W_DIV'(DIV - 1));

  always_comb begin
    idx_d  = idx_q;
    led_d  = led_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    cnt_d  = cnt_q;
    up     = 1'b1;
    if (load) begin
      idx_d = sel;
      cnt_d = '0;
      if (chg && mode_in == M_BOUNCE) dir_d = 1'b1;
    end else if (chg) begin
      cnt_d = '0;
      if (mode_in == M_BOUNCE) dir_d = 1'b1;
    end else if (en) begin
      unique case (mode_in)
        M_DECODE, M_THERMO: begin
          idx_d = sel;
          cnt_d = '0;
        end
        M_WALK: begin
          if (tick) begin
            cnt_d  = '0;
            idx_d  = idx_q + 1'b1;
            wrap_d = (idx_q == '1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        M_BOUNCE: begin
          if (tick) begin
            cnt_d = '0;
            // An endpoint reached with a stale direction reverses instead of overrunning.
            up     = (dir_q && idx_q != '1) || (!dir_q && idx_q == '0);
            idx_d  = up ? idx_q + 1'b1 : idx_q - 1'b1;
            dir_d  = (idx_d == '1) ? 1'b0 : (idx_d == '0) ? 1'b1 : up;
            wrap_d = !up && (idx_d == '0);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (load || chg || en) led_d = pattern(mode_in, idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q  <= '0;
      idx_q  <= '0;
      dir_q  <= 1'b1;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
      mode_q <= M_DECODE;
    end else begin
      led_q  <= led_d;
      idx_q  <= idx_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_in;
    end
  end

`ifdef ONEHOT_DECODER_SEQ_CHECK_EN
  logic primed_q;
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (load) err_d = 1'b0;
    else if (primed_q && mode_q != M_THERMO && $countones(led_q) != 1) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      primed_q <= 1'b1;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign led  = led_q;
  assign idx  = idx_q;
  assign dir  = dir_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Scoreboard bench: two decoder instances (W_IN=3/DIV=2 and W_IN=2/DIV=1) against a phase-based model.
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] sel = '0;
  logic       load = 1'b0;

  logic [7:0] led_a;
  logic [2:0] idx_a;
  logic       dir_a, wrap_a, err_a;
  logic [3:0] led_b;
  logic [1:0] idx_b;
  logic       dir_b, wrap_b, err_b;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  onehot_decoder_seq #(.W_IN(3), .DIV(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load),
    .led(led_a), .idx(idx_a), .dir(dir_a), .wrap(wrap_a), .err(err_a)
  );

  onehot_decoder_seq #(.W_IN(2), .DIV(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[1:0]), .load(load),
    .led(led_b), .idx(idx_b), .dir(dir_b), .wrap(wrap_b), .err(err_b)
  );

  typedef struct {
    int     idx, dir, wrap, cnt, mode, primed, err;
    longint led;
  } mst_t;

  localparam mst_t RST = '{idx: 0, dir: 1, wrap: 0, cnt: 0, mode: 0, primed: 0, err: 0, led: 0};

  mst_t ma, mb;
  mst_t qa[$];
  mst_t qb[$];

  function automatic longint pat(int m, int i);
    if (m == 1) return (longint'(2) << i) - 1;
    return longint'(1) << i;
  endfunction

  function automatic int ones(longint v);
    int c = 0;
    for (int k = 0; k < 64; k++) c += int'(v[k]);
    return c;
  endfunction

  // Bounce is modelled as a phase p on a 2*(N-1) triangle; idx and dir are read off p.
  function automatic mst_t step(mst_t s, bit e, int m, int sv, bit l, int n, int div);
    mst_t r = s;
    bit chg = (m != s.mode);
    int top = n - 1;
    int p;
    r.wrap = 0;
    r.mode = m;
    if (l) begin
      r.idx = sv; r.cnt = 0;
      if (chg && m == 3) r.dir = 1;
    end else if (chg) begin
      r.cnt = 0;
      if (m == 3) r.dir = 1;
    end else if (e) begin
      if (m < 2) begin
        r.idx = sv; r.cnt = 0;
      end else if (s.cnt == div - 1) begin
        r.cnt = 0;
        if (m == 2) begin
          r.idx  = (s.idx + 1) % n;
          r.wrap = (r.idx == 0);
        end else begin
          p = s.dir ? s.idx : (s.idx == 0 ? 0 : 2*top - s.idx);
          p = (p + 1) % (2*top);
          r.idx  = (p <= top) ? p : 2*top - p;
          r.dir  = (p < top);
          r.wrap = (p == 0);
        end
      end else begin
        r.cnt = s.cnt + 1;
      end
    end
    if (l || chg || e) r.led = pat(m, r.idx);
`ifdef ONEHOT_DECODER_SEQ_CHECK_EN
    r.primed = 1;
    if (l) r.err = 0;
    else if (s.primed != 0 && s.mode != 1 && ones(s.led) != 1) r.err = 1;
`endif
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit e, bit [1:0] m, bit [2:0] s, bit l);
    @(negedge clk);
    rst = 1'b0; en = e; mode = m; sel = s; load = l;
    ma = step(ma, e, int'(m), int'(s), l, 8, 2);
    mb = step(mb, e, int'(m), int'(s[1:0]), l, 4, 1);
    qa.push_back(ma);
    qb.push_back(mb);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_led_a", 64'(led_a), 64'd0);
    chk("rst_idx_a", 64'(idx_a), 64'd0);
    chk("rst_wrap_a", 64'(wrap_a), 64'd0);
    chk("rst_dir_a", 64'(dir_a), 64'd1);
    chk("rst_led_b", 64'(led_b), 64'd0);
    chk("rst_idx_b", 64'(idx_b), 64'd0);
    chk("rst_err_b", 64'(err_b), 64'd0);
    ma = RST;
    mb = RST;
  endtask

  initial begin
    mst_t ea, eb;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && !done) begin
        if (qa.size() == 0 || qb.size() == 0) begin
          chk("scoreboard_underflow", 64'(qa.size()), 64'd1);
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          chk("led_a", 64'(led_a), 64'(ea.led));
          chk("idx_a", 64'(idx_a), 64'(ea.idx));
          chk("dir_a", 64'(dir_a), 64'(ea.dir));
          chk("wrap_a", 64'(wrap_a), 64'(ea.wrap));
          chk("err_a", 64'(err_a), 64'(ea.err));
          chk("led_b", 64'(led_b), 64'(eb.led));
          chk("idx_b", 64'(idx_b), 64'(eb.idx));
          chk("dir_b", 64'(dir_b), 64'(eb.dir));
          chk("wrap_b", 64'(wrap_b), 64'(eb.wrap));
          chk("err_b", 64'(err_b), 64'(eb.err));
        end
      end
    end
  end

  initial begin
    bit [1:0] mcur;
    int r;
    ma = RST;
    mb = RST;
    do_reset();
    // decode then thermometer
    drive(1, 2'd0, 3'd5, 0); drive(1, 2'd0, 3'd0, 0);
    drive(1, 2'd1, 3'd7, 0); drive(1, 2'd1, 3'd2, 0); drive(1, 2'd1, 3'd0, 0);
    // walk from 6, then freeze with en low
    drive(1, 2'd2, 3'd6, 1);
    repeat (8) drive(1, 2'd2, 3'd0, 0);
    repeat (5) drive(0, 2'd2, 3'd0, 0);
    repeat (3) drive(1, 2'd2, 3'd0, 0);
    // bounce from idx 0
    drive(1, 2'd3, 3'd0, 1);
    repeat (10) drive(1, 2'd3, 3'd0, 0);
    // async reset mid-walk
    repeat (3) drive(1, 2'd2, 3'd0, 0);
    do_reset();
    repeat (3) drive(1, 2'd2, 3'd0, 0);
    // load colliding with a mode change on a prescaler tick
    drive(1, 2'd2, 3'd1, 1);
    drive(1, 2'd2, 3'd0, 0);
    drive(1, 2'd3, 3'd3, 1);
    repeat (4) drive(1, 2'd3, 3'd0, 0);
    // randomized traffic
    mcur = 2'd2;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else begin
        if (r < 10) mcur = 2'($urandom_range(0, 3));
        drive($urandom_range(0, 9) != 0, mcur, 3'($urandom), $urandom_range(0, 19) == 0);
      end
    end
    @(posedge clk);
    #3 done = 1'b1;
    chk("scoreboard_drained", 64'(qa.size() + qb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
